// File: rtl/led_pwm_driver.sv
// led_pwm_driver: LED brightness stepper with glitch-free PWM output.
// Each i_step pulse moves the level OFF->LOW->MID->HIGH->OFF; i_off forces OFF.
// The level state is visible directly on o_level.
// Optional macro LED_PWM_FADE_EN: when defined, the duty ramps by one count
// every FADE_STEP_CYCLES toward the selected level. When undefined, the duty
// loads the level's value directly and o_busy is tied low.
// Handshake: i_step / i_off are single-cycle strobes, sampled on every rising
// i_clk edge; there is no back-pressure.
module led_pwm_driver #(
    parameter int PWM_PERIOD       = 1000,
    parameter int DUTY_LOW         = 250,
    parameter int DUTY_MID         = 500,
    parameter int DUTY_HIGH        = 1000,
    parameter int FADE_STEP_CYCLES = 5000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_step,
    input  logic       i_off,
    output logic       o_pwm,
    output logic [1:0] o_level,
    output logic       o_busy
);

    localparam int DW = $clog2(PWM_PERIOD + 1);
    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_HIGH = 2'd3
    } level_t;

    level_t        state_q;
    level_t        state_d;
    logic [DW-1:0] tgt_duty;
    logic [DW-1:0] cur_duty_q;
    logic [DW-1:0] cur_duty_d;
    logic [DW-1:0] app_duty_q;
    logic [CW-1:0] cnt_q;
    logic          cnt_wrap;
    logic          pwm_q;
    logic          busy_q;

    function automatic logic [DW-1:0] duty_of(input level_t lvl);
        logic [DW-1:0] d;
        case (lvl)
            ST_LOW:  d = DW'(DUTY_LOW);
            ST_MID:  d = DW'(DUTY_MID);
            ST_HIGH: d = DW'(DUTY_HIGH);
            default: d = '0;
        endcase
        return d;
    endfunction

    // Level state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next level: i_off has priority over i_step; HIGH wraps back to OFF.
    always_comb begin
        state_d = state_q;
        if (i_off) begin
            state_d = ST_OFF;
        end else if (i_step) begin
            state_d = level_t'(state_q + 2'd1);
        end
    end

    // Level outputs: the exposed level and its target duty.
    always_comb begin
        o_level  = state_q;
        tgt_duty = duty_of(state_q);
    end

`ifdef LED_PWM_FADE_EN
    localparam int RW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

    logic [RW-1:0] ramp_q;
    logic          ramp_wrap;
    logic [DW-1:0] tgt_duty_d;

    assign ramp_wrap  = (ramp_q == RW'(FADE_STEP_CYCLES - 1));
    assign tgt_duty_d = duty_of(state_d);

    // Free-running ramp prescaler; level changes never restart it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ramp_q <= '0;
        end else if (ramp_wrap) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_q + RW'(1);
        end
    end

    // Move the current duty one count toward the target on each ramp tick.
    always_comb begin
        cur_duty_d = cur_duty_q;
        if (ramp_wrap) begin
            if (cur_duty_q < tgt_duty) begin
                cur_duty_d = cur_duty_q + DW'(1);
            end else if (cur_duty_q > tgt_duty) begin
                cur_duty_d = cur_duty_q - DW'(1);
            end
        end
    end

    // Busy is computed from next-state values so it rises with o_level.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (cur_duty_d != tgt_duty_d);
        end
    end
`else
    // Without fading, the current duty follows the target one cycle later.
    always_comb begin
        cur_duty_d = tgt_duty;
    end

    assign busy_q = 1'b0;
`endif

    // Current duty register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cur_duty_q <= '0;
        end else begin
            cur_duty_q <= cur_duty_d;
        end
    end

    assign cnt_wrap = (cnt_q == CW'(PWM_PERIOD - 1));

    // PWM counter, period-boundary duty latch and registered compare.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q      <= '0;
            app_duty_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_wrap ? '0 : cnt_q + CW'(1);
            if (cnt_wrap) begin
                app_duty_q <= cur_duty_q;
            end
            pwm_q <= (DW'(cnt_q) < app_duty_q);
        end
    end

    assign o_pwm  = pwm_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: directed bench for led_pwm_driver with a 10-cycle period.
// Follows whichever build of the design is compiled (LED_PWM_FADE_EN or not).
`timescale 1ns/1ps
module tb_led_pwm_driver;

    localparam int P  = 10;
    localparam int DL = 3;
    localparam int DM = 6;
    localparam int DH = 10;
    localparam int F  = 2;

    logic       i_clk     = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_step    = 1'b0;
    logic       i_off     = 1'b0;
    logic       o_pwm;
    logic [1:0] o_level;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    logic [1:0] exp_q[$];
    int         duty_tab[4];

    led_pwm_driver #(
        .PWM_PERIOD      (P),
        .DUTY_LOW        (DL),
        .DUTY_MID        (DM),
        .DUTY_HIGH       (DH),
        .FADE_STEP_CYCLES(F)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_step   (i_step),
        .i_off    (i_off),
        .o_pwm    (o_pwm),
        .o_level  (o_level),
        .o_busy   (o_busy)
    );

    // Clock and reset-relative edge counter (edge k after release: PWM count = k mod P).
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) edge_n <= 0;
        else            edge_n <= edge_n + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            tick(1);
            if (o_pwm === 1'b1) c++;
        end
    endtask

    task automatic pulse_step();
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
    endtask

    task automatic pulse_off();
        i_off = 1'b1;
        tick(1);
        i_off = 1'b0;
    endtask

    initial begin
        int c;
        int n;
        int s;
        int prev;
        int cur;
        int mx;
        bit ok;

        duty_tab[0] = DL;
        duty_tab[1] = DM;
        duty_tab[2] = DH;
        duty_tab[3] = 0;

        // Reset held 5 cycles, released away from the clock edge.
        repeat (5) @(posedge i_clk);
        #1;
        chk("reset_pwm_in_reset", o_pwm, 0);
        i_reset_n = 1'b1;
        chk("reset_level", o_level, 0);
        chk("reset_busy", o_busy, 0);
        count_high(50, c);
        chk("reset_pwm_quiet_50", c, 0);

        // Single step, issued so the level changes on an edge with count 3.
        n = 0;
        while ((edge_n % P) != 2 && n < 20) begin
            tick(1);
            n++;
        end
        pulse_step();
        s = edge_n;
        chk("step_level_low", o_level, 1);
`ifdef LED_PWM_FADE_EN
        chk("step_busy_rise", o_busy, 1);
        n = 0;
        while (o_busy !== 1'b0 && n < 30) begin
            tick(1);
            n++;
        end
        chk("step_busy_fall_cycles", edge_n - s, 5);
        tick(20);
        count_high(10, c);
        chk("low_high_time", c, DL);
`else
        chk("step_busy_zero", o_busy, 0);
        tick(1);
        chk("step_duty_direct", dut.cur_duty_q, DL);
        n = 0;
        ok = 1'b1;
        while (o_pwm !== 1'b1 && n < 30) begin
            if (o_busy !== 1'b0) ok = 1'b0;
            tick(1);
            n++;
        end
        chk("first_high_offset", edge_n - s, 8);
        chk("first_high_phase", edge_n % P, 1);
        count_high(9, c);
        chk("first_period_high_time", c + 1, DL);
        chk("busy_stays_zero", ok, 1);
`endif
        pulse_off();
        chk("off_level", o_level, 0);
        tick(40);

        // Four steps spaced ~100 cycles: LOW, MID, HIGH, OFF.
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        for (int i = 0; i < 4; i++) begin
            pulse_step();
            chk($sformatf("seq_level_%0d", i), o_level, exp_q.pop_front());
            tick(60);
            count_high(30, c);
            chk($sformatf("seq_high_30_%0d", i), c, duty_tab[i] * 3);
            chk($sformatf("seq_busy_idle_%0d", i), o_busy, 0);
            tick(8);
        end

        // Step and off together at MID: off wins.
        pulse_step();
        pulse_step();
        tick(40);
        chk("pre_offwin_level_mid", o_level, 2);
        i_step = 1'b1;
        i_off  = 1'b1;
        tick(1);
        i_step = 1'b0;
        i_off  = 1'b0;
        chk("offwin_level", o_level, 0);
`ifdef LED_PWM_FADE_EN
        chk("offwin_busy", o_busy, 1);
        prev = int'(dut.cur_duty_q);
        chk("offwin_duty_start", prev, DM);
        ok = 1'b1;
        repeat (30) begin
            tick(1);
            cur = int'(dut.cur_duty_q);
            if (cur > prev || prev - cur > 1) ok = 1'b0;
            prev = cur;
        end
        chk("offwin_ramp_monotonic", ok, 1);
        chk("offwin_duty_end", dut.cur_duty_q, 0);
        chk("offwin_busy_end", o_busy, 0);

        // Off mid-ramp at duty 2 of target 6: reverse without a jump.
        i_step = 1'b1;
        tick(2);
        i_step = 1'b0;
        chk("midramp_level_mid", o_level, 2);
        n = 0;
        while (dut.cur_duty_q !== 4'd2 && n < 20) begin
            tick(1);
            n++;
        end
        chk("midramp_reached_2", dut.cur_duty_q, 2);
        pulse_off();
        chk("midramp_level_off", o_level, 0);
        prev = int'(dut.cur_duty_q);
        chk("midramp_no_jump", prev, 2);
        ok = 1'b1;
        mx = prev;
        repeat (20) begin
            tick(1);
            cur = int'(dut.cur_duty_q);
            if (cur > prev || prev - cur > 1) ok = 1'b0;
            if (cur > mx) mx = cur;
            prev = cur;
        end
        chk("midramp_monotonic", ok, 1);
        chk("midramp_max", mx, 2);
        chk("midramp_duty_end", dut.cur_duty_q, 0);
`else
        tick(1);
        chk("offwin_duty_direct", dut.cur_duty_q, 0);
        tick(30);
        count_high(20, c);
        chk("offwin_pwm_low", c, 0);
`endif

        // Asynchronous reset while o_pwm is high.
        pulse_step();
        tick(40);
        n = 0;
        while (o_pwm !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("prereset_pwm_high", o_pwm, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("async_reset_pwm", o_pwm, 0);
        chk("async_reset_level", o_level, 0);
        chk("async_reset_busy", o_busy, 0);
        tick(2);
        i_reset_n = 1'b1;
        count_high(20, c);
        chk("post_reset_pwm_quiet", c, 0);
        chk("post_reset_level", o_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
